// File: rtl/strm_arbiter_pkg.sv
// Shared widths and FSM encoding for the tx-stream arbiter.
package strm_arbiter_pkg;

    localparam int unsigned STRM_DATA_W  = 32;
    localparam int unsigned STRM_COUNT_W = 8;
    localparam int unsigned STRM_ID_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/strm_rr_pick.sv
// Combinational round-robin picker: first set request after `last`, wrapping.
module strm_rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);

    int unsigned cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last) + k) % NUM_REQ;
            if (!found && req[IDX_W'(cand)]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/strm_arbiter.sv
// Round-robin, per-message arbiter sharing the encoder's tx-stream input
// between NUM_REQ producers; flags pulls that arrive with no owner.
module strm_arbiter
    import strm_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ*STRM_DATA_W-1:0]  req_data,
    input  logic [NUM_REQ*STRM_COUNT_W-1:0] req_count,
    input  logic [NUM_REQ*STRM_ID_W-1:0]    req_id,
    input  logic [NUM_REQ-1:0]            req_avail,
    output logic [NUM_REQ-1:0]            req_pull,
    input  logic [NUM_REQ-1:0]            enable_mask,
    output logic [STRM_DATA_W-1:0]        strm_data,
    output logic [STRM_COUNT_W-1:0]       strm_count,
    output logic [STRM_ID_W-1:0]          strm_id,
    output logic                          strm_avail,
    input  logic                          strm_pull,
    output logic                          grant_valid,
    output logic [IDX_W-1:0]              grant_idx,
    output logic                          proto_err
);

    arb_state_t              state, state_nxt;
    logic [IDX_W-1:0]        grant_idx_nxt;
    logic [IDX_W-1:0]        last_q, last_nxt;
    logic [STRM_COUNT_W-1:0] remaining, remaining_nxt;
    logic                    started, started_nxt;
    logic                    proto_err_nxt;

    logic                    pick_found;
    logic [IDX_W-1:0]        pick_idx;
    logic [STRM_COUNT_W-1:0] pick_count;
    logic                    sel_avail;
    logic                    own;

    assign own         = (state == OWN);
    assign grant_valid = own;

    strm_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req   (req_avail & enable_mask),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Owner mux to the encoder, pull steering and count of the pick candidate
    always_comb begin
        strm_data  = '0;
        strm_count = '0;
        strm_id    = '0;
        sel_avail  = 1'b0;
        req_pull   = '0;
        pick_count = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (own && grant_idx == IDX_W'(i)) begin
                strm_data   = req_data[i*STRM_DATA_W +: STRM_DATA_W];
                strm_count  = req_count[i*STRM_COUNT_W +: STRM_COUNT_W];
                strm_id     = req_id[i*STRM_ID_W +: STRM_ID_W];
                sel_avail   = req_avail[i];
                req_pull[i] = strm_pull;
            end
            if (pick_idx == IDX_W'(i)) begin
                pick_count = req_count[i*STRM_COUNT_W +: STRM_COUNT_W];
            end
        end
    end

    // Offer only until the first pull so the encoder never restarts a message
    assign strm_avail = own & ~started & sel_avail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        grant_idx_nxt = grant_idx;
        last_nxt      = last_q;
        remaining_nxt = remaining;
        started_nxt   = started;
        proto_err_nxt = proto_err;
        case (state)
            IDLE: begin
                if (strm_pull) begin
                    proto_err_nxt = 1'b1;
                end
                if (pick_found) begin
                    state_nxt     = OWN;
                    grant_idx_nxt = pick_idx;
                    last_nxt      = pick_idx;
                    remaining_nxt = pick_count;
                    started_nxt   = 1'b0;
                end
            end
            OWN: begin
                // count 0 loads 0 and wraps, releasing on the 256th pull
                if (strm_pull) begin
                    started_nxt   = 1'b1;
                    remaining_nxt = remaining - STRM_COUNT_W'(1);
                    if (remaining == STRM_COUNT_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_idx <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            remaining <= '0;
            started   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            grant_idx <= grant_idx_nxt;
            last_q    <= last_nxt;
            remaining <= remaining_nxt;
            started   <= started_nxt;
            proto_err <= proto_err_nxt;
        end
    end

endmodule

// File: tb/tb_strm_arbiter.sv
// Randomized bench for strm_arbiter against a message-level round-robin model.
module tb_strm_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned IDX_W = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N*32-1:0]  req_data;
    logic [N*8-1:0]   req_count;
    logic [N*4-1:0]   req_id;
    logic [N-1:0]     req_avail;
    logic [N-1:0]     req_pull;
    logic [N-1:0]     enable_mask;
    logic [31:0]      strm_data;
    logic [7:0]       strm_count;
    logic [3:0]       strm_id;
    logic             strm_avail;
    logic             strm_pull;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             proto_err;

    strm_arbiter #(.NUM_REQ(N), .IDX_W(IDX_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_data    (req_data),
        .req_count   (req_count),
        .req_id      (req_id),
        .req_avail   (req_avail),
        .req_pull    (req_pull),
        .enable_mask (enable_mask),
        .strm_data   (strm_data),
        .strm_count  (strm_count),
        .strm_id     (strm_id),
        .strm_avail  (strm_avail),
        .strm_pull   (strm_pull),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    // Model: owner (-1 = none), pulls still owed, last winner, sticky error
    int m_owner, m_idx, m_last, m_left;
    bit m_started, m_err;

    int p_left[N];
    bit reoffer[N];
    int dut_pulls[N];
    int glog[$];
    bit prev_valid;
    int pull_prob;
    bit pull_force;
    bit rand_mode;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1; m_idx = 0; m_last = N - 1; m_left = 0;
        m_started = 0; m_err = 0;
    endtask

    task automatic model_clock();
        int j;
        if (!rst_n) begin
            model_reset();
        end else if (m_owner >= 0) begin
            if (strm_pull) begin
                m_started = 1;
                m_left--;
                if (m_left == 0) m_owner = -1;
            end
        end else begin
            if (strm_pull) m_err = 1;
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (req_avail[j] && enable_mask[j]) begin
                    m_owner = j; m_idx = j; m_last = j; m_started = 0;
                    m_left = (req_count[j*8 +: 8] == 8'd0) ? 256 : int'(req_count[j*8 +: 8]);
                    break;
                end
            end
        end
    endtask

    task automatic offer(input int i, input logic [7:0] cnt, input logic [3:0] id);
        req_avail[i]         = 1'b1;
        req_count[i*8 +: 8]  = cnt;
        req_id[i*4 +: 4]     = id;
        req_data[i*32 +: 32] = $urandom;
        p_left[i]            = (cnt == 8'd0) ? 256 : int'(cnt);
    endtask

    task automatic clear_logs();
        glog.delete();
        for (int i = 0; i < N; i++) dut_pulls[i] = 0;
    endtask

    // Check at negedge, advance model at posedge, update producers/encoder after
    task automatic tick();
        logic [N-1:0] e_pull;
        logic [31:0]  e_data;
        logic [7:0]   e_cnt;
        logic [3:0]   e_id;
        logic         e_avail;
        @(negedge clk);
        e_pull = '0; e_data = '0; e_cnt = '0; e_id = '0; e_avail = 1'b0;
        if (m_owner >= 0) begin
            if (strm_pull) e_pull[m_owner] = 1'b1;
            e_data  = req_data[m_owner*32 +: 32];
            e_cnt   = req_count[m_owner*8 +: 8];
            e_id    = req_id[m_owner*4 +: 4];
            e_avail = !m_started && req_avail[m_owner];
        end
        check("grant_valid", 64'(grant_valid), 64'(m_owner >= 0));
        check("grant_idx",   64'(grant_idx),   64'(m_idx));
        check("strm_avail",  64'(strm_avail),  64'(e_avail));
        check("req_pull",    64'(req_pull),    64'(e_pull));
        check("strm_data",   64'(strm_data),   64'(e_data));
        check("strm_count",  64'(strm_count),  64'(e_cnt));
        check("strm_id",     64'(strm_id),     64'(e_id));
        check("proto_err",   64'(proto_err),   64'(m_err));
        for (int i = 0; i < N; i++) dut_pulls[i] += int'(req_pull[i]);
        if (grant_valid && !prev_valid) glog.push_back(int'(grant_idx));
        prev_valid = grant_valid;
        @(posedge clk);
        model_clock();
        #1;
        for (int i = 0; i < N; i++) begin
            if (e_pull[i]) begin
                p_left[i]--;
                req_data[i*32 +: 32] = $urandom;
                if (p_left[i] <= 0) begin
                    if (reoffer[i]) offer(i, req_count[i*8 +: 8], req_id[i*4 +: 4]);
                    else req_avail[i] = 1'b0;
                end
            end
        end
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                if (!req_avail[i] && $urandom_range(9) == 0)
                    offer(i, ($urandom_range(19) == 0) ? 8'd0 : 8'($urandom_range(1, 6)), 4'($urandom));
            end
            if ($urandom_range(19) == 0) enable_mask = N'($urandom);
        end
        strm_pull = rst_n && (pull_force || (m_owner >= 0 && int'($urandom_range(99)) < pull_prob));
    endtask

    task automatic wait_grants(input int n, input int budget, input string tag);
        int c = 0;
        while (glog.size() < n && c < budget) begin tick(); c++; end
        check(tag, 64'(glog.size() >= n), 64'(1));
    endtask

    task automatic drain(input int budget, input string tag);
        int c = 0;
        while ((req_avail != '0 || m_owner >= 0) && c < budget) begin tick(); c++; end
        check(tag, 64'(req_avail == '0 && !grant_valid), 64'(1));
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; req_data = '0; req_count = '0; req_id = '0; req_avail = '0;
        enable_mask = '1; strm_pull = 1'b0;
        pull_prob = 0; pull_force = 0; rand_mode = 0; prev_valid = 0;
        for (int i = 0; i < N; i++) begin p_left[i] = 0; reoffer[i] = 0; end
        model_reset();
        clear_logs();
        repeat (2) @(posedge clk);
        #1;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Single-word message, id 3
        clear_logs(); pull_prob = 100;
        offer(0, 8'd1, 4'd3);
        wait_grants(1, 10, "t1_grant");
        drain(20, "t1_drain");
        check("t1_owner", 64'(glog[0]), 64'(0));
        check("t1_pulls", 64'(dut_pulls[0]), 64'(1));

        // Three-word message with sparse pulls
        clear_logs(); pull_prob = 20;
        offer(1, 8'd3, 4'd5);
        wait_grants(1, 10, "t2_grant");
        drain(300, "t2_drain");
        check("t2_pulls", 64'(dut_pulls[1]), 64'(3));

        // Two continuous requesters; last winner was 1 so 2 goes first
        clear_logs(); pull_prob = 100;
        reoffer[0] = 1; reoffer[2] = 1;
        offer(0, 8'd2, 4'h1); offer(2, 8'd2, 4'h2);
        wait_grants(4, 100, "t3_grants");
        reoffer[0] = 0; reoffer[2] = 0;
        drain(100, "t3_drain");
        check("t3_order0", 64'(glog[0]), 64'(2));
        check("t3_order1", 64'(glog[1]), 64'(0));
        check("t3_order2", 64'(glog[2]), 64'(2));
        check("t3_order3", 64'(glog[3]), 64'(0));

        // Masked requester 0 waits until the mask reopens
        clear_logs(); pull_prob = 50;
        enable_mask = 4'b1110;
        offer(0, 8'd3, 4'h6); offer(1, 8'd3, 4'h7);
        wait_grants(1, 20, "t4_grant1");
        enable_mask = '1;
        wait_grants(2, 100, "t4_grant2");
        drain(100, "t4_drain");
        check("t4_first", 64'(glog[0]), 64'(1));
        check("t4_second", 64'(glog[1]), 64'(0));

        // count 0 means 256 words
        clear_logs(); pull_prob = 70;
        offer(3, 8'd0, 4'h7);
        drain(1000, "t5_drain");
        check("t5_pulls", 64'(dut_pulls[3]), 64'(256));

        // Pull with no owner sets the sticky error
        clear_logs();
        strm_pull = 1'b1;
        tick();
        repeat (3) tick();
        check("t6_err_sticky", 64'(proto_err), 64'(1));
        check("t6_no_pull", 64'(dut_pulls[0] + dut_pulls[1] + dut_pulls[2] + dut_pulls[3]), 64'(0));

        // Reset mid-message drops the grant and clears the error
        pull_prob = 100;
        offer(2, 8'd5, 4'h9);
        wait_grants(1, 10, "t6_grant");
        tick(); tick();
        rst_n = 1'b0; strm_pull = 1'b0;
        tick();
        check("t6_rst_valid", 64'(grant_valid), 64'(0));
        check("t6_rst_pull", 64'(req_pull), 64'(0));
        check("t6_rst_err", 64'(proto_err), 64'(0));
        rst_n = 1'b1;
        req_avail = '0;
        for (int i = 0; i < N; i++) p_left[i] = 0;
        tick();

        // Random traffic
        clear_logs(); pull_prob = 60; rand_mode = 1;
        repeat (3000) tick();
        rand_mode = 0; enable_mask = '1;
        drain(3000, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
